// File: rtl/ahbl_dual_master_arbiter_if.sv
// AHB-Lite bus bundle shared by the two upstream ports and the downstream port.
interface ahbl_dual_master_arbiter_if #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
);
    logic [W_ADDR-1:0] haddr;
    logic              hwrite;
    logic [1:0]        htrans;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [3:0]        hprot;
    logic              hmastlock;
    logic [W_DATA-1:0] hwdata;
    logic              hready;
    logic              hresp;
    logic [W_DATA-1:0] hrdata;

    modport master (
        output haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hwdata,
        input  hready, hresp, hrdata
    );

    modport slave (
        input  haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hwdata,
        output hready, hresp, hrdata
    );
endinterface

// File: rtl/ahbl_dual_master_arbiter.sv
// Two-to-one AHB-Lite arbiter merging Hazard3 I/D ports onto one master port.
// Define AHBL_ARB_ROUND_ROBIN_EN for alternating grants; default is D over I.
module ahbl_dual_master_arbiter #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    ahbl_dual_master_arbiter_if.slave  i,
    ahbl_dual_master_arbiter_if.slave  d,
    ahbl_dual_master_arbiter_if.master m
);

    typedef struct packed {
        logic [W_ADDR-1:0] addr;
        logic              write;
        logic [1:0]        trans;
        logic [2:0]        size;
        logic [2:0]        burst;
        logic [3:0]        prot;
        logic              lock;
    } aph_t;

    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} own_t;

    own_t own_q, own_nxt;
    aph_t live_i, live_d, buf_i, buf_d, sel_i, sel_d, aph;
    logic buf_vld_i, buf_vld_d, dph_i, dph_d, d_lock_q;
    logic hready_i, hready_d, acc_i, acc_d, req_i, req_d;
    logic can_gnt, lock_hold, prio_d, gnt_i, gnt_d;
    logic [W_DATA-1:0] wdata;

    assign live_i = {i.haddr, i.hwrite, i.htrans, i.hsize,
                     i.hburst, i.hprot, i.hmastlock};
    assign live_d = {d.haddr, d.hwrite, d.htrans, d.hsize,
                     d.hburst, d.hprot, d.hmastlock};

    assign hready_i = !dph_i || (own_q == OWN_I && m.hready);
    assign hready_d = !dph_d || (own_q == OWN_D && m.hready);
    assign acc_i = i.htrans[1] && hready_i;
    assign acc_d = d.htrans[1] && hready_d;
    assign req_i = buf_vld_i || acc_i;
    assign req_d = buf_vld_d || acc_d;
    assign sel_i = buf_vld_i ? buf_i : live_i;
    assign sel_d = buf_vld_d ? buf_d : live_d;

    // A locked D sequence keeps the bus until D issues an unlocked phase
    assign lock_hold = (own_q == OWN_D) && d_lock_q;
    assign can_gnt = m.hready && !reset;

`ifdef AHBL_ARB_ROUND_ROBIN_EN
    logic rr_last;
    assign prio_d = !rr_last;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_last <= 1'b0;
        end else if (gnt_d) begin
            rr_last <= 1'b1;
        end else if (gnt_i) begin
            rr_last <= 1'b0;
        end
    end
`else
    assign prio_d = 1'b1;
`endif

    assign gnt_d = can_gnt && req_d && (lock_hold || !req_i || prio_d);
    assign gnt_i = can_gnt && req_i && !lock_hold && !gnt_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            own_q <= OWN_NONE;
        end else begin
            own_q <= own_nxt;
        end
    end

    always_comb begin
        own_nxt = own_q;
        if (m.hready) begin
            own_nxt = gnt_d ? OWN_D : (gnt_i ? OWN_I : OWN_NONE);
        end
    end

    always_comb begin
        aph = gnt_i ? sel_i : sel_d;
        m.haddr     = aph.addr;
        m.hwrite    = aph.write;
        m.htrans    = (gnt_i || gnt_d) ? aph.trans : 2'b00;
        m.hsize     = aph.size;
        m.hburst    = aph.burst;
        m.hprot     = aph.prot;
        m.hmastlock = aph.lock;
        wdata       = (own_q == OWN_D) ? d.hwdata : i.hwdata;
        m.hwdata    = wdata;
        i.hready    = hready_i;
        d.hready    = hready_d;
        i.hresp     = (own_q == OWN_I) && m.hresp;
        d.hresp     = (own_q == OWN_D) && m.hresp;
        i.hrdata    = m.hrdata;
        d.hrdata    = m.hrdata;
    end

    // A losing accepted phase parks in the buffer; hready stays low meanwhile
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buf_vld_i <= 1'b0;
            buf_vld_d <= 1'b0;
            buf_i     <= '0;
            buf_d     <= '0;
            dph_i     <= 1'b0;
            dph_d     <= 1'b0;
            d_lock_q  <= 1'b0;
        end else begin
            if (gnt_i) begin
                buf_vld_i <= 1'b0;
            end else if (acc_i) begin
                buf_vld_i <= 1'b1;
                buf_i     <= live_i;
            end
            if (gnt_d) begin
                buf_vld_d <= 1'b0;
            end else if (acc_d) begin
                buf_vld_d <= 1'b1;
                buf_d     <= live_d;
            end
            if (hready_i) begin
                dph_i <= i.htrans[1];
            end
            if (hready_d) begin
                dph_d <= d.htrans[1];
            end
            if (gnt_d) begin
                d_lock_q <= sel_d.lock;
            end
        end
    end

endmodule

// File: tb/tb_ahbl_dual_master_arbiter.sv
// Directed-vector bench for ahbl_dual_master_arbiter.
// Covers lone/contended/locked/error/reset cases in either arbitration mode.
module tb_ahbl_dual_master_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int miscompares = 0;

    ahbl_dual_master_arbiter_if #(.W_ADDR(32), .W_DATA(32)) ib ();
    ahbl_dual_master_arbiter_if #(.W_ADDR(32), .W_DATA(32)) db ();
    ahbl_dual_master_arbiter_if #(.W_ADDR(32), .W_DATA(32)) mb ();

    ahbl_dual_master_arbiter #(.W_ADDR(32), .W_DATA(32)) dut (
        .clock(clock),
        .reset(reset),
        .i(ib),
        .d(db),
        .m(mb)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic idle_all();
        ib.haddr = '0; ib.hwrite = 0; ib.htrans = 0; ib.hsize = 3'd2;
        ib.hburst = 0; ib.hprot = 4'h3; ib.hmastlock = 0; ib.hwdata = '0;
        db.haddr = '0; db.hwrite = 0; db.htrans = 0; db.hsize = 3'd2;
        db.hburst = 0; db.hprot = 4'h3; db.hmastlock = 0; db.hwdata = '0;
        mb.hready = 1; mb.hresp = 0; mb.hrdata = '0;
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        idle_all();
        next();
        next();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1;
        @(negedge clock);
        vectors++;
        if (ib.hready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_i_hready: got %b want 1", ib.hready);
        end
        vectors++;
        if (db.hready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_d_hready: got %b want 1", db.hready);
        end
        vectors++;
        if ({ib.hresp, db.hresp} !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_hresp: got %b want 00", {ib.hresp, db.hresp});
        end
        vectors++;
        if (mb.htrans !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_m_htrans: got %h want 0", mb.htrans);
        end
        next();
        reset = 0;
    endtask

    task automatic test_lone_i_read();
        ib.htrans = 2'b10; ib.haddr = 32'h100;
        @(negedge clock);
        vectors++;
        if (mb.haddr !== 32'h100 || mb.htrans !== 2'b10) begin
            miscompares++;
            $display("FAIL lone_addr: got %h/%h want 00000100/2",
                     mb.haddr, mb.htrans);
        end
        vectors++;
        if (ib.hready !== 1'b1) begin
            miscompares++;
            $display("FAIL lone_aph_ready: got %b want 1", ib.hready);
        end
        next();
        ib.htrans = 0;
        mb.hrdata = 32'h1234_5678;
        @(negedge clock);
        vectors++;
        if (ib.hready !== 1'b1 || ib.hrdata !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL lone_data: got %b/%h want 1/12345678",
                     ib.hready, ib.hrdata);
        end
        next();
        mb.hrdata = '0;
    endtask

    task automatic test_simultaneous();
        ib.htrans = 2'b10; ib.haddr = 32'h100; ib.hwrite = 0;
        db.htrans = 2'b10; db.haddr = 32'h2000; db.hwrite = 1;
        @(negedge clock);
        vectors++;
        if (mb.haddr !== 32'h2000 || mb.hwrite !== 1'b1) begin
            miscompares++;
            $display("FAIL sim_d_first: got %h/%b want 00002000/1",
                     mb.haddr, mb.hwrite);
        end
        next();
        ib.htrans = 0;
        db.htrans = 0; db.hwrite = 0;
        db.hwdata = 32'hDEAD_BEEF;
        @(negedge clock);
        vectors++;
        if (ib.hready !== 1'b0) begin
            miscompares++;
            $display("FAIL sim_i_wait: got %b want 0", ib.hready);
        end
        vectors++;
        if (mb.haddr !== 32'h100 || mb.htrans !== 2'b10) begin
            miscompares++;
            $display("FAIL sim_i_issue: got %h/%h want 00000100/2",
                     mb.haddr, mb.htrans);
        end
        vectors++;
        if (mb.hwdata !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL sim_hwdata: got %h want deadbeef", mb.hwdata);
        end
        next();
        db.hwdata = '0;
        @(negedge clock);
        vectors++;
        if (ib.hready !== 1'b1) begin
            miscompares++;
            $display("FAIL sim_i_done: got %b want 1", ib.hready);
        end
        next();
    endtask

    task automatic test_lock();
        ib.htrans = 2'b10; ib.haddr = 32'h100;
        db.htrans = 2'b10; db.haddr = 32'h40; db.hmastlock = 1;
        @(negedge clock);
        vectors++;
        if (mb.haddr !== 32'h40 || mb.hmastlock !== 1'b1) begin
            miscompares++;
            $display("FAIL lock_first: got %h/%b want 00000040/1",
                     mb.haddr, mb.hmastlock);
        end
        next();
        db.hmastlock = 0; db.hwrite = 1;
        @(negedge clock);
        vectors++;
        if (mb.haddr !== 32'h40 || mb.hwrite !== 1'b1 ||
            mb.hmastlock !== 1'b0) begin
            miscompares++;
            $display("FAIL lock_unlock: got %h/%b/%b want 00000040/1/0",
                     mb.haddr, mb.hwrite, mb.hmastlock);
        end
        next();
        db.htrans = 0; db.hwrite = 0;
        ib.htrans = 0;
        @(negedge clock);
        vectors++;
        if (mb.haddr !== 32'h100 || mb.htrans !== 2'b10) begin
            miscompares++;
            $display("FAIL lock_i_after: got %h/%h want 00000100/2",
                     mb.haddr, mb.htrans);
        end
        next();
        next();
    endtask

    task automatic test_error();
        ib.htrans = 2'b10; ib.haddr = 32'h500;
        db.htrans = 2'b10; db.haddr = 32'h3000;
        @(negedge clock);
        vectors++;
        if (mb.haddr !== 32'h3000) begin
            miscompares++;
            $display("FAIL err_d_issue: got %h want 00003000", mb.haddr);
        end
        next();
        ib.htrans = 0; db.htrans = 0;
        mb.hready = 0; mb.hresp = 1;
        @(negedge clock);
        vectors++;
        if (db.hresp !== 1'b1 || db.hready !== 1'b0) begin
            miscompares++;
            $display("FAIL err_cycle1: got %b/%b want resp 1 ready 0",
                     db.hresp, db.hready);
        end
        vectors++;
        if (ib.hresp !== 1'b0 || mb.htrans !== 2'b00) begin
            miscompares++;
            $display("FAIL err_cycle1_i: got %b/%h want 0/0",
                     ib.hresp, mb.htrans);
        end
        next();
        mb.hready = 1;
        @(negedge clock);
        vectors++;
        if (db.hresp !== 1'b1 || db.hready !== 1'b1 || ib.hresp !== 1'b0) begin
            miscompares++;
            $display("FAIL err_cycle2: got %b/%b/%b want 1/1/0",
                     db.hresp, db.hready, ib.hresp);
        end
        vectors++;
        if (mb.haddr !== 32'h500 || mb.htrans !== 2'b10) begin
            miscompares++;
            $display("FAIL err_i_after: got %h/%h want 00000500/2",
                     mb.haddr, mb.htrans);
        end
        next();
        mb.hresp = 0;
        @(negedge clock);
        vectors++;
        if (ib.hready !== 1'b1 || ib.hresp !== 1'b0) begin
            miscompares++;
            $display("FAIL err_i_data: got %b/%b want 1/0",
                     ib.hready, ib.hresp);
        end
        next();
    endtask

`ifdef AHBL_ARB_ROUND_ROBIN_EN
    task automatic test_round_robin();
        logic [31:0] want;
        do_reset();
        ib.htrans = 2'b10; ib.haddr = 32'h100;
        db.htrans = 2'b10; db.haddr = 32'h2000;
        for (int c = 0; c < 8; c++) begin
            want = (c % 2 == 0) ? 32'h2000 : 32'h100;
            @(negedge clock);
            vectors++;
            if (mb.haddr !== want || mb.htrans !== 2'b10) begin
                miscompares++;
                $display("FAIL rr_cycle%0d: got %h/%h want %h/2",
                         c, mb.haddr, mb.htrans, want);
            end
            next();
        end
        ib.htrans = 0; db.htrans = 0;
        next();
        next();
    endtask
`else
    task automatic test_fixed_priority();
        do_reset();
        ib.htrans = 2'b10; ib.haddr = 32'h100;
        db.htrans = 2'b10; db.haddr = 32'h2000;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            vectors++;
            if (mb.haddr !== 32'h2000) begin
                miscompares++;
                $display("FAIL fix_cycle%0d: got %h want 00002000",
                         c, mb.haddr);
            end
            next();
        end
        db.htrans = 0; ib.htrans = 0;
        @(negedge clock);
        vectors++;
        if (mb.haddr !== 32'h100 || mb.htrans !== 2'b10) begin
            miscompares++;
            $display("FAIL fix_i_release: got %h/%h want 00000100/2",
                     mb.haddr, mb.htrans);
        end
        next();
        next();
    endtask
`endif

    task automatic test_reset_mid();
        mb.hready = 0;
        ib.htrans = 2'b10; ib.haddr = 32'h700;
        @(negedge clock);
        vectors++;
        if (mb.htrans !== 2'b00) begin
            miscompares++;
            $display("FAIL mid_no_issue: got %h want 0", mb.htrans);
        end
        next();
        ib.htrans = 0;
        @(negedge clock);
        vectors++;
        if (ib.hready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_buffered: got %b want 0", ib.hready);
        end
        reset = 1;
        #1;
        vectors++;
        if (ib.hready !== 1'b1 || db.hready !== 1'b1 ||
            mb.htrans !== 2'b00) begin
            miscompares++;
            $display("FAIL mid_reset: got %b/%b/%h want 1/1/0",
                     ib.hready, db.hready, mb.htrans);
        end
        next();
        reset = 0;
        mb.hready = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            vectors++;
            if (mb.htrans !== 2'b00 || ib.hready !== 1'b1) begin
                miscompares++;
                $display("FAIL mid_after%0d: got %h/%b want 0/1",
                         c, mb.htrans, ib.hready);
            end
            next();
        end
    endtask

    initial begin
        idle_all();
        test_reset();
        test_lone_i_read();
        test_simultaneous();
        test_lock();
        test_error();
`ifdef AHBL_ARB_ROUND_ROBIN_EN
        test_round_robin();
`else
        test_fixed_priority();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ahbl_dual_master_arbiter.md
# ahbl_dual_master_arbiter

Two-to-one AHB-Lite arbiter that merges the Hazard3 instruction-fetch port (i_*) and load/store port (d_*) onto one downstream AHB-Lite master port (m_*), so a 2-port core can drive a single-port memory or interconnect. Each upstream port has a one-entry address-phase buffer, so a transfer that loses arbitration is held rather than lost. Data-phase signals are routed by a registered data-phase owner. Locked d-side sequences and two-cycle error responses are passed through intact.

## Interface
- W_ADDR, 32, address width
- W_DATA, 32, data width
- clock  in  1  clock
- reset  in  1  asynchronous, active-high reset
- i_haddr, d_haddr  in  W_ADDR  upstream address
- i_hwrite, d_hwrite  in  1  upstream write flag
- i_htrans, d_htrans  in  2  upstream transfer type; bit 1 is the request
- i_hsize, d_hsize  in  3  upstream size
- i_hburst, d_hburst  in  3  upstream burst (forwarded unchanged)
- i_hprot, d_hprot  in  4  upstream protection
- i_hmastlock, d_hmastlock  in  1  upstream lock
- i_hwdata, d_hwdata  in  W_DATA  upstream write data
- i_hready, d_hready  out  1  upstream ready; reset 1
- i_hresp, d_hresp  out  1  upstream error; reset 0
- i_hrdata, d_hrdata  out  W_DATA  upstream read data (m_hrdata fanned out)
- m_haddr, m_hwrite, m_htrans, m_hsize, m_hburst, m_hprot, m_hmastlock  out  per upstream widths  downstream address phase; m_htrans reset IDLE (0)
- m_hwdata  out  W_DATA  downstream write data, muxed by data-phase owner
- m_hready, m_hresp  in  1  downstream ready/response
- m_hrdata  in  W_DATA  downstream read data

## Operation
- **State per port X (I or D).**
  - buf_vld_X plus a copy of haddr/hwrite/htrans/hsize/hburst/hprot/hmastlock.
  - dph_X: X owns an outstanding upstream data phase.
- **Shared state.** own_m (NONE/I/D): owner of the downstream data phase. rr_last: last grantee, used only with round-robin.
- **Request.** req_X = buf_vld_X, or (X_htrans[1] and X_hready).
  - Buffered content takes precedence over live bus content.
- **Grant.** Evaluated only when m_hready=1.
  - Fixed priority: D over I.
  - If own_m=D and the last D address phase had hmastlock=1, D is granted and I is blocked until a D address phase with hmastlock=0 is issued.
- **Issue.** Granted request drives m_*. No grant drives m_htrans=IDLE and the m_* address fields from port D.
- **Acceptance.** An upstream address phase with htrans[1]=1 and X_hready=1 is accepted.
  - If it is issued in the same cycle with m_hready=1: dph_X set, own_m←X.
  - Otherwise: it is captured into buf_X and dph_X set.
  - An accepted IDLE/BUSY on X clears dph_X once its zero-wait-state phase ends.
- **Upstream ready.** X_hready = !dph_X, or (own_m=X and m_hready).
  - X_hready is low while its transfer waits in buf_X.
- **Upstream response.** X_hresp = (own_m=X) and m_hresp. X_hrdata = m_hrdata.
- **Write data.** m_hwdata = own_m=D ? d_hwdata : i_hwdata.
- **Error.** Downstream two-cycle error is forwarded cycle-for-cycle to the owner; buf_X is never cancelled by an error.
- **Reset.** All buffers invalid, dph_* clear, own_m=NONE, rr_last=I.

## Timing
- Uncontended transfer: zero added latency; the address phase reaches m_* combinationally in the same cycle.
- Buffered transfer: issued no earlier than the cycle after capture; upstream sees at least 1 extra wait state.
- At most one outstanding downstream data phase; the arbiter adds no pipeline bubble between back-to-back grants.
- Simultaneous I and D requests with an idle downstream: one is issued, the other is buffered in the same edge.
- A buffer never refills while valid, because X_hready is low.
- Reset asserted mid-transfer drops all state immediately. Upstream hready returns to 1 and m_htrans to IDLE; the downstream slave must be reset together with the arbiter.

## Configuration
- AHBL_ARB_ROUND_ROBIN_EN defined:
  - Grant alternates: when both request, grant the port ≠ rr_last.
  - rr_last updates on every issued NONSEQ/SEQ.
  - The lock rule still overrides.
- Undefined: fixed D-over-I priority; rr_last is not implemented.

## Test plan
- **Lone I read.** I NONSEQ read 0x100, m_hready always 1 → m_haddr=0x100 in the same cycle; i_hrdata=m_hrdata one cycle later; 0 added wait states.
- **Simultaneous requests, fixed priority.** I reads 0x100 and D writes 0x2000 with data 0xDEADBEEF in the same cycle → D issued first, I buffered. I is issued the next cycle; i_hready is low for 1 cycle; m_hwdata=0xDEADBEEF during the D data phase.
- **Round-robin.** With AHBL_ARB_ROUND_ROBIN_EN, both ports request continuously for 8 cycles → grants alternate D,I,D,I… starting with D after reset (rr_last=I).
- **Lock.** D issues locked read 0x40 then unlocked write 0x40 while I requests throughout → I is not issued until the cycle after the unlocked D write address phase.
- **Error.** D read 0x3000 gets downstream error (hresp=1,hready=0 then hresp=1,hready=1) → d_hresp matches both cycles; i_hresp stays 0; a buffered I transfer is issued afterwards.
- **Reset mid-transfer.** Reset asserted with buf_I valid and m_hready=0 → i_hready=1, d_hready=1, m_htrans=IDLE immediately; no buffered transfer issues after release.
